// File: rtl/display_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_regs_pkg
// Purpose  : Shared constants for the dashboard display register bank:
//            field indices, default geometry and the number of meaningful
//            bits in each legacy field.
// Ports    : none (package)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package display_regs_pkg;

  // Default bank geometry
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_TIMEOUT  = 50000;

  // Field index map
  localparam int IDX_SPEED     = 0;
  localparam int IDX_RTD       = 1;
  localparam int IDX_CAR_BATT  = 2;
  localparam int IDX_DISP_BATT = 3;
  localparam int IDX_GPS       = 4;
  localparam int IDX_ERR       = 5;

  // Meaningful bits per field. Every field is stored at full width and the
  // consumer slices it. Ready-to-drive lives in bit 1 only.
  localparam int VW_SPEED     = 8;
  localparam int VW_RTD       = 1;
  localparam int RTD_BIT      = 1;
  localparam int VW_CAR_BATT  = 8;
  localparam int VW_DISP_BATT = 2;
  localparam int VW_GPS       = 2;
  localparam int VW_ERR       = 8;

  typedef enum logic [2:0] {
    FLD_SPEED     = 3'd0,
    FLD_RTD       = 3'd1,
    FLD_CAR_BATT  = 3'd2,
    FLD_DISP_BATT = 3'd3,
    FLD_GPS       = 3'd4,
    FLD_ERR       = 3'd5
  } field_e;

  // Mask of the meaningful bits of an 8-bit field, for consumers.
  function automatic logic [7:0] valid_mask(input int idx);
    logic [7:0] m;
    m = 8'hFF;
    case (idx)
      IDX_RTD:       m = 8'(1 << RTD_BIT);
      IDX_DISP_BATT: m = 8'((1 << VW_DISP_BATT) - 1);
      IDX_GPS:       m = 8'((1 << VW_GPS) - 1);
      default:       m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : display_reg_bank_if
// Purpose  : Write / commit / readback bus of the display register bank.
// Signals  : wr_en, addr, wr_data  - single-cycle field write
//            commit                - copy shadow bank to live bank
//            rd_addr, rd_data      - registered readback of the live bank
// Modports : master (bus driver), slave (register bank)
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface display_reg_bank_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              commit;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_en, addr, wr_data, commit, rd_addr, input rd_data);
  modport slave  (input wr_en, addr, wr_data, commit, rd_addr, output rd_data);
endinterface
`default_nettype wire

// File: rtl/display_reg_bank_stale_timer.sv
`default_nettype none
// ============================================================================
// Module   : stale_timer
// Purpose  : Per-field age counter. Saturates at TIMEOUT; o_stale is high
//            while saturated. Comes out of reset saturated.
// Ports    : clk, rst_n  - clock, async active-low reset
//            i_restart   - field written this cycle (age back to 0)
//            o_stale     - age has reached TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module stale_timer #(
  parameter int TIMEOUT = 50000,
  parameter int TMR_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_stale
);

  localparam logic [TMR_W-1:0] c_limit = TMR_W'(TIMEOUT);

  logic [TMR_W-1:0] r_tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= c_limit;
    end else if (i_restart) begin
      r_tmr <= '0;
    end else if (r_tmr != c_limit) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // Decoded straight from the counter so stale drops the cycle after a write.
  assign o_stale = (r_tmr == c_limit);

endmodule
`default_nettype wire

// File: rtl/display_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : display_reg_bank
// Purpose  : Double-buffered dashboard telemetry register file. Writes land
//            in a shadow bank; commit copies the whole shadow bank to the
//            live bank at once so the renderer never sees a torn frame.
// Ports    : clk, rst_n     - clock, async active-low reset
//            bus (slave)    - write / commit / readback bus
//            o_live_flat    - live bank, field i at [i*DATA_W +: DATA_W]
//            o_changed      - one-cycle pulse per field altered by a commit
//            o_pending      - field written since the last commit
//            o_stale        - field not written for TIMEOUT cycles
//            o_wr_err       - one-cycle pulse on an out-of-range write
// Revision : 1.0 - initial parametrised release
// ============================================================================
module display_reg_bank
  import display_regs_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = 3,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TMR_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  display_reg_bank_if.slave          bus,
  output logic [NUM_REGS*DATA_W-1:0] o_live_flat,
  output logic [NUM_REGS-1:0]        o_changed,
  output logic [NUM_REGS-1:0]        o_pending,
  output logic [NUM_REGS-1:0]        o_stale,
  output logic                       o_wr_err
);

  logic [DATA_W-1:0]   w_live [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_hit;
  logic                w_addr_ok;
  logic                w_rd_ok;
  logic                w_wr_ok;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_wr_err;

  assign w_addr_ok = 32'(bus.addr) < NUM_REGS;
  assign w_rd_ok   = 32'(bus.rd_addr) < NUM_REGS;
  assign w_wr_ok   = bus.wr_en && w_addr_ok;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_field
    localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(i);

    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_live;
    logic              r_changed;
    logic              r_pending;

    assign w_wr_hit[i] = w_wr_ok && (bus.addr == c_idx);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow  <= '0;
        r_live    <= '0;
        r_changed <= 1'b0;
        r_pending <= 1'b0;
      end else begin
        if (w_wr_hit[i]) begin
          r_shadow <= bus.wr_data;
        end
        // Commit takes the shadow value from before any same-cycle write;
        // that write stays pending for the following commit.
        if (bus.commit) begin
          r_live <= r_shadow;
        end
        r_changed <= bus.commit && (r_shadow != r_live);
        r_pending <= w_wr_hit[i] | (r_pending & ~bus.commit);
      end
    end

    stale_timer #(
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
    ) u_stale_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (w_wr_hit[i]),
      .o_stale   (o_stale[i])
    );

    assign w_live[i]                       = r_live;
    assign o_live_flat[i*DATA_W +: DATA_W] = r_live;
    assign o_changed[i]                    = r_changed;
    assign o_pending[i]                    = r_pending;
  end

  // Readback reflects the live bank as it was before this cycle's commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_rd_data <= w_rd_ok ? w_live[bus.rd_addr] : '0;
      r_wr_err  <= bus.wr_en && !w_addr_ok;
    end
  end

  assign bus.rd_data = r_rd_data;
  assign o_wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_display_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_reg_bank
// Purpose  : Self-checking bench for display_reg_bank (6 fields, TIMEOUT 20)
//            with a field-level reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_reg_bank;

  localparam int NR = 6;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int TO = 20;

  logic clk;
  logic rst_n;
  logic [NR*DW-1:0] o_live_flat;
  logic [NR-1:0]    o_changed;
  logic [NR-1:0]    o_pending;
  logic [NR-1:0]    o_stale;
  logic             o_wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  display_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  display_reg_bank #(
    .NUM_REGS (NR),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .TIMEOUT  (TO),
    .TMR_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_live_flat (o_live_flat),
    .o_changed   (o_changed),
    .o_pending   (o_pending),
    .o_stale     (o_stale),
    .o_wr_err    (o_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (field-level) ----------------
  logic [DW-1:0] m_shadow [8];
  logic [DW-1:0] m_live   [8];
  int            m_age    [8];   // cycles since last write, clamped at TO
  logic [NR-1:0] m_changed;
  logic [NR-1:0] m_pending;
  logic [DW-1:0] m_rd;
  logic          m_wr_err;
  logic          m_ok;

  assign m_ok = bus.wr_en && (int'(bus.addr) < NR);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] <= '0;
        m_live[i]   <= '0;
        m_age[i]    <= TO;
      end
      m_changed <= '0;
      m_pending <= '0;
      m_rd      <= '0;
      m_wr_err  <= 1'b0;
    end else begin
      m_wr_err <= bus.wr_en && !m_ok;
      m_rd     <= (int'(bus.rd_addr) < NR) ? m_live[bus.rd_addr] : '0;
      for (int i = 0; i < NR; i++) begin
        m_changed[i] <= bus.commit && (m_shadow[i] != m_live[i]);
        if (bus.commit) m_live[i] <= m_shadow[i];
        if (m_ok && int'(bus.addr) == i) begin
          m_shadow[i]  <= bus.wr_data;
          m_pending[i] <= 1'b1;
          m_age[i]     <= 0;
        end else begin
          m_pending[i] <= bus.commit ? 1'b0 : m_pending[i];
          m_age[i]     <= (m_age[i] < TO) ? m_age[i] + 1 : TO;
        end
      end
    end
  end

  function automatic logic [NR*DW-1:0] exp_live();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_live[i];
    return v;
  endfunction

  function automatic logic [NR-1:0] exp_stale();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = (m_age[i] >= TO);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_live_flat", 64'(o_live_flat), 64'(exp_live()));
      check("m_rd_data",   64'(bus.rd_data), 64'(m_rd));
      check("m_changed",   64'(o_changed),   64'(m_changed));
      check("m_pending",   64'(o_pending),   64'(m_pending));
      check("m_stale",     64'(o_stale),     64'(exp_stale()));
      check("m_wr_err",    64'(o_wr_err),    64'(m_wr_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
  endtask

  initial begin
    int wr_pct;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    bus.commit  = 1'b0;
    bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) tick();

    // Reset state
    check("rst_live",    64'(o_live_flat), 64'h0);
    check("rst_rd",      64'(bus.rd_data), 64'h0);
    check("rst_stale",   64'(o_stale),     64'h3F);
    check("rst_pending", 64'(o_pending),   64'h0);
    check("rst_changed", 64'(o_changed),   64'h0);

    // Write without commit stays out of live
    drive_wr(3'd0, 8'h3C);
    tick();
    bus.wr_en = 1'b0;
    check("wr0_pending", 64'(o_pending), 64'h01);
    check("wr0_stale",   64'(o_stale),   64'h3E);
    tick();
    check("wr0_rd",      64'(bus.rd_data), 64'h0);

    // Commit publishes it
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    check("c1_live0",   64'(o_live_flat[7:0]), 64'h3C);
    check("c1_changed", 64'(o_changed),        64'h01);
    check("c1_pending", 64'(o_pending),        64'h0);
    check("c1_rd_pre",  64'(bus.rd_data),      64'h0);
    tick();
    check("c1_pulse",   64'(o_changed),   64'h0);
    check("c1_rd_post", 64'(bus.rd_data), 64'h3C);

    // Write in the commit cycle stays pending
    drive_wr(3'd5, 8'h0A);
    tick();
    drive_wr(3'd2, 8'h55);
    bus.commit = 1'b1;
    tick();
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    check("c2_changed", 64'(o_changed),          64'h20);
    check("c2_pending", 64'(o_pending),          64'h04);
    check("c2_live5",   64'(o_live_flat[47:40]), 64'h0A);
    check("c2_live2",   64'(o_live_flat[23:16]), 64'h00);
    bus.commit = 1'b1;
    tick();
    check("c3_changed", 64'(o_changed),          64'h04);
    check("c3_live2",   64'(o_live_flat[23:16]), 64'h55);
    tick();
    bus.commit = 1'b0;
    check("c4_b2b_changed", 64'(o_changed), 64'h0);

    // Out-of-range write and readback
    drive_wr(3'd7, 8'hFF);
    bus.rd_addr = 3'd7;
    tick();
    bus.wr_en = 1'b0;
    check("oor_wr_err",  64'(o_wr_err),  64'h1);
    check("oor_pending", 64'(o_pending), 64'h0);
    check("oor_rd",      64'(bus.rd_data), 64'h0);
    tick();
    check("oor_pulse", 64'(o_wr_err), 64'h0);
    bus.rd_addr = 3'd2;

    // Staleness: single write at cycle T
    drive_wr(3'd1, 8'h02);
    tick();
    bus.wr_en = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      check("stale1_single", 64'(o_stale[1]), 64'(k >= 21));
      tick();
    end
    // Rewrite at T+15 pushes reassertion to T+36
    drive_wr(3'd1, 8'h00);
    tick();
    for (int k = 1; k <= 40; k++) begin
      bus.wr_en = (k == 15);
      check("stale1_rewrite", 64'(o_stale[1]), 64'(k >= 36));
      tick();
    end
    bus.wr_en = 1'b0;

    // Asynchronous reset with pending data
    drive_wr(3'd3, 8'h77);
    tick();
    bus.wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_live",    64'(o_live_flat), 64'h0);
    check("arst_pending", 64'(o_pending),   64'h0);
    check("arst_stale",   64'(o_stale),     64'h3F);
    check("arst_rd",      64'(bus.rd_data), 64'h0);
    #2 rst_n = 1'b1;
    tick();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    check("arst_commit_changed", 64'(o_changed), 64'h0);

    // Randomized traffic, alternating dense and sparse write phases
    for (int seg = 0; seg < 10; seg++) begin
      wr_pct = (seg % 2 == 0) ? 60 : 4;
      for (int c = 0; c < 200; c++) begin
        bus.wr_en   = ($urandom_range(0, 99) < wr_pct);
        bus.addr    = AW'($urandom_range(0, 7));
        bus.wr_data = DW'($urandom);
        bus.commit  = ($urandom_range(0, 5) == 0);
        bus.rd_addr = AW'($urandom_range(0, 7));
        if ($urandom_range(0, 299) == 0) begin
          #3 rst_n = 1'b0;
          #2 rst_n = 1'b1;
        end
        tick();
      end
    end
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
